// File: rtl/mem_wait_responder.sv
// Data-memory responder with a valid/ready request side, programmable read/write
// wait states and a one-cycle registered response pulse (Moore FSM).
module mem_wait_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(STRB_WIDTH);
    localparam int IDX_W      = ADDR_WIDTH - OFF_W;
    localparam int DEPTH      = 1 << IDX_W;
    localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   lat_we;
    logic                   lat_err;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [STRB_WIDTH-1:0]  lat_wstrb;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]       word_idx;
    logic                   misaligned;
    logic                   mem_wr;

    assign misaligned = |(req_addr & OFF_MASK);
    assign word_idx   = IDX_W'(lat_addr >> OFF_W);
    assign busy       = ~req_ready;

    // A write commits only on the last wait edge; a reset on that edge wins.
    assign mem_wr = (state == S_WAIT) && (cnt == '0) && lat_we && !lat_err && !RST;

    always_ff @(posedge CLK) begin
        if (mem_wr) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (lat_wstrb[b]) begin
                    mem[word_idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Misaligned requests take one WAIT cycle with no access so that their
    // response lands after the same edge as a one-cycle access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_err   <= misaligned;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        state     <= S_WAIT;
                        if (misaligned) begin
                            cnt <= '0;
                        end else if (req_we) begin
                            cnt <= CNT_W'(WRITE_LATENCY - 1);
                        end else begin
                            cnt <= CNT_W'(READ_LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!lat_err && !lat_we) begin
                            rsp_rdata <= mem[word_idx];
                        end
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_err;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench: a default-latency instance driven from a vector table, plus a
// WRITE_LATENCY=3 instance used for the reset-during-write case.
module tb_mem_wait_responder;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int checks   = 0;
    int failures = 0;

    mem_wait_responder u_fast (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_wstrb (req_wstrb[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0]),
        .busy      (busy[0])
    );

    mem_wait_responder #(.WRITE_LATENCY(3)) u_slow (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_wstrb (req_wstrb[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1]),
        .busy      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one handshake on instance d; returns at the sample where rsp_valid
    // is high (lat = cycles after acceptance edge) or lat = -1 on timeout.
    task automatic applyStimulus(input int d, input vec_t v, output int lat, output logic busy_ok);
        int guard;
        guard   = 0;
        busy_ok = 1'b1;
        while (!req_ready[d] && guard < 20) begin
            step();
            guard++;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = v.we;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        req_wstrb[d] = v.wstrb;
        step();
        req_valid[d] = 1'b0;
        req_we[d]    = ~v.we;
        req_addr[d]  = 12'($urandom);
        req_wdata[d] = $urandom;
        req_wstrb[d] = 4'hF;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (req_ready[d] || !busy[d]) busy_ok = 1'b0;
            if (rsp_valid[d]) begin
                lat = k - 1;
                break;
            end
            step();
        end
    endtask

    task automatic runVector(input int d, input string tag, input vec_t v);
        int   lat;
        logic busy_ok;
        applyStimulus(d, v, lat, busy_ok);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({tag, "_err"}, 32'(rsp_err[d]), 32'(v.exp_err));
        checkOutput({tag, "_rdata"}, rsp_rdata[d], v.exp_rdata);
        checkOutput({tag, "_busy_in_flight"}, 32'(busy_ok), 32'd1);
        step();
        checkOutput({tag, "_pulse_end"}, 32'(rsp_valid[d]), 32'd0);
        checkOutput({tag, "_err_clear"}, 32'(rsp_err[d]), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(req_ready[d]), 32'd1);
    endtask

    vec_t vecs [14];

    initial begin
        logic [11:0] ready_mask;
        logic [11:0] rsp_mask;
        logic [11:0] busy_mask;
        logic        saw_rsp;
        vec_t        v;

        //             we    addr     wdata         wstrb lat  err   rdata
        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 4'd1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 12'h010, 32'hFFFFFFFF, 4'hF, 4'd2, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 12'h010, 32'h11223344, 4'h5, 4'd1, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 12'h010, 32'h00000000, 4'hF, 4'd2, 1'b0, 32'hDE22BE44};
        vecs[4]  = '{1'b0, 12'h013, 32'h00000000, 4'hF, 4'd1, 1'b1, 32'hDE22BE44};
        vecs[5]  = '{1'b1, 12'h012, 32'hFFFFFFFF, 4'hF, 4'd1, 1'b1, 32'hDE22BE44};
        vecs[6]  = '{1'b0, 12'h010, 32'h00000000, 4'h0, 4'd2, 1'b0, 32'hDE22BE44};
        vecs[7]  = '{1'b1, 12'h014, 32'hAABBCCDD, 4'hF, 4'd1, 1'b0, 32'hDE22BE44};
        vecs[8]  = '{1'b1, 12'h014, 32'h12345678, 4'h0, 4'd1, 1'b0, 32'hDE22BE44};
        vecs[9]  = '{1'b0, 12'h014, 32'h00000000, 4'hF, 4'd2, 1'b0, 32'hAABBCCDD};
        vecs[10] = '{1'b1, 12'hFFC, 32'h0BADF00D, 4'hF, 4'd1, 1'b0, 32'hAABBCCDD};
        vecs[11] = '{1'b0, 12'hFFC, 32'h00000000, 4'hF, 4'd2, 1'b0, 32'h0BADF00D};
        vecs[12] = '{1'b0, 12'h011, 32'h00000000, 4'hF, 4'd1, 1'b1, 32'h0BADF00D};
        vecs[13] = '{1'b0, 12'h010, 32'h00000000, 4'hF, 4'd2, 1'b0, 32'hDE22BE44};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wstrb[d] = '0;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset%0d_ready", d), 32'(req_ready[d]), 32'd1);
            checkOutput($sformatf("reset%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            checkOutput($sformatf("reset%0d_rdata", d), rsp_rdata[d], 32'd0);
            checkOutput($sformatf("reset%0d_busy", d), 32'(busy[d]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Seed the slow instance before the table runs on the fast one.
        v = '{1'b1, 12'h020, 32'h12345678, 4'hF, 4'd3, 1'b0, 32'h0};
        runVector(1, "slow_seed_write", v);

        for (int i = 0; i < 14; i++) begin
            runVector(0, $sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back reads with req_valid held high.
        req_we[0]    = 1'b0;
        req_addr[0]  = 12'h010;
        req_wstrb[0] = 4'hF;
        req_valid[0] = 1'b1;
        ready_mask = '0;
        rsp_mask   = '0;
        busy_mask  = '0;
        for (int i = 0; i < 12; i++) begin
            ready_mask[i] = req_ready[0];
            busy_mask[i]  = busy[0];
            rsp_mask[i]   = rsp_valid[0];
            if (rsp_valid[0]) checkOutput($sformatf("b2b_rdata%0d", i), rsp_rdata[0], 32'hDE22BE44);
            step();
        end
        req_valid[0] = 1'b0;
        checkOutput("b2b_ready_pattern", 32'(ready_mask), 32'h111);
        checkOutput("b2b_rsp_pattern", 32'(rsp_mask), 32'h888);
        checkOutput("b2b_busy_pattern", 32'(busy_mask), 32'hEEE);
        step();

        // Reset during the WAIT of a three-cycle write on the slow instance.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 12'h020;
        req_wdata[1] = 32'hCAFEF00D;
        req_wstrb[1] = 4'hF;
        step();
        req_valid[1] = 1'b0;
        saw_rsp = rsp_valid[1];
        step();
        checkOutput("midrst_busy_before", 32'(busy[1]), 32'd1);
        saw_rsp |= rsp_valid[1];
        rst = 1'b1;
        step();
        saw_rsp |= rsp_valid[1];
        step();
        saw_rsp |= rsp_valid[1];
        rst = 1'b0;
        checkOutput("midrst_ready", 32'(req_ready[1]), 32'd1);
        checkOutput("midrst_busy", 32'(busy[1]), 32'd0);
        checkOutput("midrst_rdata", rsp_rdata[1], 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            saw_rsp |= rsp_valid[1];
        end
        checkOutput("midrst_no_response", 32'(saw_rsp), 32'd0);
        v = '{1'b0, 12'h020, 32'h0, 4'hF, 4'd2, 1'b0, 32'h12345678};
        runVector(1, "midrst_readback", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
